sprite_fetch_arbiter: RTL
=========================

Name: sprite_fetch_arbiter

Overview:
- Shares the packed sprite image store (all sprite bitmaps, row-major, one `imagewidth`-bit word per row) among several draw units (title, dinosaur and cactus renderers).
- Each requester asks for a burst of consecutive rows of one sprite.
- The arbiter grants requesters round-robin and streams one registered row word per cycle to the owner.
- Sits between the image loader and the frame/VGA draw logic.

Parameters:
- NREQ, 3, number of requesters.
- IMGCNT, 3, number of sprites in the image store; top level ties this to `imagecount.
- IMGW, 32, row width in pixels; top level ties this to `imagewidth.
- IMGH, 32, rows per sprite; top level ties this to `imageheight.
- Derived widths:
  - IDW = max(1, clog2(IMGCNT))
  - ROWW = max(1, clog2(IMGH))
  - LENW = clog2(IMGH+1)

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset. Clock is clk; reset is rst_n, asynchronous, active-low.
- image  in  IMGCNT*IMGW*IMGH  packed sprite store. Row k of sprite s is at bit s*IMGW*IMGH + k*IMGW, IMGW bits wide.
- req  in  NREQ  per-requester request level.
- req_id  in  NREQ*IDW  sprite index per requester (slice i*IDW).
- req_row  in  NREQ*ROWW  start row per requester.
- req_len  in  NREQ*LENW  burst length in rows. 0 is treated as 1.
- rvalid  out  1  data beat valid.
- rowner  out  NREQ  one-hot owner of the current beat.
- rdata  out  IMGW  row word.
- rlast  out  1  final beat of the burst.
- rerr  out  1  beat addressed an invalid sprite or row; rdata is 0 on that beat.

Behaviour:
- Reset (rst_n low, asynchronous): rvalid=0, rowner=0, rdata=0, rlast=0, rerr=0; state IDLE; RR pointer=0. Applies mid-burst too; the burst is dropped with no further beats.
- FSM states: IDLE, BURST.
- IDLE:
  - At each clk edge, eligible = req & ~(rowner & {NREQ{rvalid & rlast}}). This masks a requester whose final beat is on the outputs this cycle, since its req may still be high.
  - If eligible is nonzero, winner w = first set bit searching from pointer upward, wrapping modulo NREQ.
  - Latch id, start row, and len (0 becomes 1).
  - Emit beat 0 registered on the same edge: rvalid=1, rowner=onehot(w), rlast=(len==1).
  - Pointer becomes (w+1) mod NREQ.
  - If len>1, go to BURST; otherwise stay in IDLE.
  - If eligible is zero: rvalid=0, rlast=0, rerr=0, rowner=0. rdata holds its last value.
- BURST:
  - One beat per cycle, row = start+beat index.
  - No new grant while in BURST. req changes are ignored.
  - rlast=1 on beat len-1, then return to IDLE.
  - Beats are back-to-back; there is no backpressure.
- Latency: request seen at edge T gives beat 0 valid after edge T; beat j valid after edge T+j.
- Next grant:
  - Earliest possible at the edge after the rlast beat.
  - If that edge is the rlast edge itself (len==1 back-to-back), the edge immediately following serves another requester.
- Error rules:
  - id >= IMGCNT: every beat has rerr=1, rdata=0.
  - row = start+j computed in ROWW+1 bits. If row >= IMGH, that beat has rerr=1, rdata=0. No wrap.
  - Burst length is always honoured.
- Requester contract: hold req, req_id, req_row, req_len stable until it sees its bit in rowner with rvalid. Drop req no later than the cycle after its rlast beat to avoid re-service.
- Simultaneous requests: round-robin only, with no starvation. With all NREQ requesting continuously using len=1, grants rotate 0,1,2,0,...

Optional Feature:
- Macro: SPRITE_FETCH_STATS_EN.
- With the macro defined:
  - Extra output stat_beats, NREQ*16 bits.
  - Per-requester saturating counter (stops at 16'hFFFF) incremented on each beat owned by that requester, including rerr beats.
  - Counters reset to 0 on rst_n.
- Without the macro: the port and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, then req=3'b010, id=1, row=4, len=1 → the edge after req rises gives rvalid=1, rowner=3'b010, rdata=dinosaur row 4, rlast=1, rerr=0. The next cycle gives rvalid=0.
- req=3'b111, all len=1, held continuously → owners 001,010,100,001,... on consecutive cycles. Any requester is re-served only after the others have been served.
- req0 holds id=2, row=30, len=4 (IMGH=32) → 4 consecutive beats. Rows 30 and 31 carry valid data with rerr=0. Beats 3 and 4 have rdata=0, rerr=1, and the 4th beat has rlast=1. Requesters 1 and 2 get no grant until the edge after rlast.
- id=3 (IMGCNT=3), len=2 → 2 beats, both with rerr=1 and rdata=0; rlast on the 2nd. len=0 → exactly 1 beat.
- Assert rst_n=0 asynchronously on beat 2 of a len=8 burst → outputs are 0 immediately. After release, the pointer is 0 and req=3'b110 grants requester 1 first.
- With SPRITE_FETCH_STATS_EN: after the bursts above, stat_beats of each requester equals its beat count. A counter preloaded to 16'hFFFE stays at 16'hFFFF after 3 beats.

Source files
------------

// File: rtl/sprite_fetch_arbiter_if.sv
// Request/response bundle between draw units and the sprite fetch arbiter.
// The arbiter sits on the slave side; draw logic and the image loader drive the master side.
interface sprite_fetch_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int IMGCNT = 3,
    parameter int IMGW   = 32,
    parameter int IMGH   = 32
);
    localparam int IDW  = (IMGCNT > 1) ? $clog2(IMGCNT) : 1;
    localparam int ROWW = (IMGH > 1) ? $clog2(IMGH) : 1;
    localparam int LENW = $clog2(IMGH + 1);

    logic [IMGCNT*IMGW*IMGH-1:0] image;
    logic [NREQ-1:0]             req;
    logic [NREQ*IDW-1:0]         req_id;
    logic [NREQ*ROWW-1:0]        req_row;
    logic [NREQ*LENW-1:0]        req_len;
    logic                        rvalid;
    logic [NREQ-1:0]             rowner;
    logic [IMGW-1:0]             rdata;
    logic                        rlast;
    logic                        rerr;

    modport master (
        output image, req, req_id, req_row, req_len,
        input  rvalid, rowner, rdata, rlast, rerr
    );

    modport slave (
        input  image, req, req_id, req_row, req_len,
        output rvalid, rowner, rdata, rlast, rerr
    );
endinterface

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter streaming bursts of sprite rows to draw units, one registered row per cycle.
// Optional per-requester beat counters are enabled with SPRITE_FETCH_STATS_EN.
`ifndef IMAGECOUNT
`define IMAGECOUNT 3
`endif
`ifndef IMAGEWIDTH
`define IMAGEWIDTH 32
`endif
`ifndef IMAGEHEIGHT
`define IMAGEHEIGHT 32
`endif

module sprite_fetch_arbiter #(
    parameter int NREQ   = 3,
    parameter int IMGCNT = `IMAGECOUNT,
    parameter int IMGW   = `IMAGEWIDTH,
    parameter int IMGH   = `IMAGEHEIGHT
) (
    input  logic clk,
    input  logic rst_n,
    sprite_fetch_arbiter_if.slave bus
`ifdef SPRITE_FETCH_STATS_EN
    ,
    output logic [NREQ*16-1:0] stat_beats
`endif
);
    localparam int IDW   = (IMGCNT > 1) ? $clog2(IMGCNT) : 1;
    localparam int ROWW  = (IMGH > 1) ? $clog2(IMGH) : 1;
    localparam int LENW  = $clog2(IMGH + 1);
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NROWS = IMGCNT * IMGH;
    localparam int AW    = (NROWS > 1) ? $clog2(NROWS) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [IDW-1:0]    id_reg, id_next;
    logic [ROWW-1:0]   start_reg, start_next;
    logic [LENW-1:0]   len_reg, len_next;
    logic [LENW-1:0]   beat_reg, beat_next;
    logic              rvalid_reg, rvalid_next;
    logic [NREQ-1:0]   rowner_reg, rowner_next;
    logic [IMGW-1:0]   rdata_reg, rdata_next;
    logic              rlast_reg, rlast_next;
    logic              rerr_reg, rerr_next;

    logic [IMGW-1:0]   rows [NROWS];
    logic [NREQ-1:0]   eligible;
    logic              found;
    int unsigned       win_idx;
    logic              emit;
    logic [IDW-1:0]    beat_id;
    logic [ROWW:0]     beat_row;
    logic              beat_last;
    logic [NREQ-1:0]   beat_owner;
    logic [ROWW-1:0]   grant_start;
    logic [LENW-1:0]   grant_len;
    logic              beat_ok;
    logic [AW-1:0]     beat_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NROWS; gi++) begin : g_rows
            assign rows[gi] = bus.image[gi*IMGW +: IMGW];
        end
    endgenerate

    // A requester whose final beat is on the outputs now may still hold req high.
    assign eligible = bus.req & ~(rowner_reg & {NREQ{rvalid_reg & rlast_reg}});

    always_comb begin
        found   = 1'b0;
        win_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && eligible[(int'(ptr_reg) + k) % NREQ]) begin
                found   = 1'b1;
                win_idx = (int'(ptr_reg) + k) % NREQ;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        id_next     = id_reg;
        start_next  = start_reg;
        len_next    = len_reg;
        beat_next   = beat_reg;
        emit        = 1'b0;
        beat_id     = id_reg;
        beat_row    = {1'b0, start_reg} + (ROWW+1)'(beat_reg);
        beat_last   = 1'b0;
        beat_owner  = rowner_reg;
        grant_start = bus.req_row[win_idx*ROWW +: ROWW];
        grant_len   = bus.req_len[win_idx*LENW +: LENW];
        if (grant_len == '0) begin
            grant_len = LENW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (found) begin
                    emit       = 1'b1;
                    beat_id    = bus.req_id[win_idx*IDW +: IDW];
                    beat_row   = {1'b0, grant_start};
                    beat_last  = (grant_len == LENW'(1));
                    beat_owner = NREQ'(1) << win_idx;
                    id_next    = beat_id;
                    start_next = grant_start;
                    len_next   = grant_len;
                    beat_next  = LENW'(1);
                    ptr_next   = (win_idx == NREQ - 1) ? '0 : PW'(win_idx + 1);
                    if (!beat_last) begin
                        state_next = BURST;
                    end
                end
            end
            BURST: begin
                emit      = 1'b1;
                beat_last = (beat_reg == len_reg - LENW'(1));
                beat_next = beat_reg + LENW'(1);
                if (beat_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Row arithmetic is one bit wider than ROWW so a burst running off the sprite errors instead of wrapping.
        beat_ok   = (int'(beat_id) < IMGCNT) && (int'(beat_row) < IMGH);
        beat_addr = AW'(int'(beat_id) * IMGH + int'(beat_row));

        rvalid_next = 1'b0;
        rowner_next = '0;
        rlast_next  = 1'b0;
        rerr_next   = 1'b0;
        rdata_next  = rdata_reg;
        if (emit) begin
            rvalid_next = 1'b1;
            rowner_next = beat_owner;
            rlast_next  = beat_last;
            rerr_next   = !beat_ok;
            rdata_next  = beat_ok ? rows[beat_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            id_reg     <= '0;
            start_reg  <= '0;
            len_reg    <= '0;
            beat_reg   <= '0;
            rvalid_reg <= 1'b0;
            rowner_reg <= '0;
            rdata_reg  <= '0;
            rlast_reg  <= 1'b0;
            rerr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            id_reg     <= id_next;
            start_reg  <= start_next;
            len_reg    <= len_next;
            beat_reg   <= beat_next;
            rvalid_reg <= rvalid_next;
            rowner_reg <= rowner_next;
            rdata_reg  <= rdata_next;
            rlast_reg  <= rlast_next;
            rerr_reg   <= rerr_next;
        end
    end

    assign bus.rvalid = rvalid_reg;
    assign bus.rowner = rowner_reg;
    assign bus.rdata  = rdata_reg;
    assign bus.rlast  = rlast_reg;
    assign bus.rerr   = rerr_reg;

`ifdef SPRITE_FETCH_STATS_EN
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (rvalid_next && rowner_next[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign stat_beats[gi*16 +: 16] = cnt_reg;
        end
    endgenerate
`endif
endmodule
